// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared AXI4-lite response codes and master arbiter FSM encoding
package axi4lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: one-hot grant and grant index from req and ptr
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0] idx;

  // Walk the search order backwards so the last hit is the first requester at or after ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (idx >= (IDX_W + 1)'(NREQ)) idx = idx - (IDX_W + 1)'(NREQ);
      if (req[idx[IDX_W-1:0]]) grant_idx = idx[IDX_W-1:0];
    end
    grant[grant_idx] = |req;
  end

endmodule

// File: rtl/axi4lite_master_arbiter.sv
// rtl/axi4lite_master_arbiter.sv - round-robin sharing of one AXI4-lite master port, one transaction in flight
module axi4lite_master_arbiter
  import axi4lite_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic [ADDR_W-1:0]        awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDR_W-1:0]        araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, g_q, grant_idx;
  logic [NREQ-1:0]   grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;

  always_ff @(posedge aclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A channel whose valid has already dropped counts as done in WR_ADDR.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    bready    = 1'b0;
    rready    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_d = req_we[grant_idx] ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: if ((!awvalid || awready) && (!wvalid || wready)) state_d = WR_RESP;
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = IDLE;
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      ptr_q     <= '0;
      g_q       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: if (|req_valid) begin
          g_q     <= grant_idx;
          addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
          wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
          awvalid <= req_we[grant_idx];
          wvalid  <= req_we[grant_idx];
          arvalid <= !req_we[grant_idx];
        end
        WR_ADDR: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
        end
        WR_RESP: if (bvalid) begin
          rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << g_q;
          rsp_resp  <= bresp;
          ptr_q     <= (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
        end
        RD_ADDR: if (arready) arvalid <= 1'b0;
        RD_DATA: if (rvalid) begin
          rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << g_q;
          rsp_rdata <= rdata;
          rsp_resp  <= rresp;
          ptr_q     <= (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// tb/tb_axi4lite_master_arbiter.sv - self-checking bench for axi4lite_master_arbiter with a delay-programmable AXI4-lite slave
module tb_axi4lite_master_arbiter;

  localparam int NREQ = 4;

  logic              aclk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [31:0]       awaddr, wdata, araddr, rdata;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [1:0]        bresp, rresp;

  axi4lite_master_arbiter #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave behaviour: ready after a programmable number of cycles, response a programmable time later.
  int          da, dw, db, dar, dr;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_ok, w_ok, ar_ok;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;

  always @(negedge aclk) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_ok = 0; w_ok = 0; ar_ok = 0;
    end else begin
      if (bvalid) bvalid = 0;
      if (rvalid) rvalid = 0;
      if (awready) begin awready = 0; aw_ok = 1; end
      else if (awvalid && !aw_ok) begin
        if (aw_cnt >= da) begin awready = 1; aw_cnt = 0; cap_awaddr = awaddr; aw_hs++; end
        else aw_cnt++;
      end
      if (wready) begin wready = 0; w_ok = 1; end
      else if (wvalid && !w_ok) begin
        if (w_cnt >= dw) begin wready = 1; w_cnt = 0; cap_wdata = wdata; w_hs++; end
        else w_cnt++;
      end
      if (aw_ok && w_ok) begin
        if (b_cnt >= db) begin
          bvalid = 1; bresp = cfg_bresp; aw_ok = 0; w_ok = 0; b_cnt = 0;
          if (bready) b_hs++;
        end else b_cnt++;
      end
      if (arready) begin arready = 0; ar_ok = 1; end
      else if (arvalid && !ar_ok) begin
        if (ar_cnt >= dar) begin arready = 1; ar_cnt = 0; cap_araddr = araddr; ar_hs++; end
        else ar_cnt++;
      end
      if (ar_ok) begin
        if (r_cnt >= dr) begin
          rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; ar_ok = 0; r_cnt = 0;
          if (rready) r_hs++;
        end else r_cnt++;
      end
    end
  end

  // Protocol monitor: grant log plus violation count (multi-hot, grant while busy or outstanding).
  int viol, rsp_count;
  int grant_log[$];
  bit outst;

  always @(negedge aclk) begin
    if (reset) outst = 0;
    else begin
      if (rsp_valid != '0) begin
        if (!$onehot(rsp_valid)) viol++;
        rsp_count++;
        outst = 0;
      end
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) viol++;
        if (awvalid || wvalid || arvalid || bready || rready || outst) viol++;
        outst = 1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) grant_log.push_back(k);
      end
    end
  end

  // Reference model: round-robin pointer and the last read word.
  int          model_ptr;
  logic [31:0] last_rd;
  logic [31:0] a_addr[NREQ], a_data[NREQ];

  function automatic int model_grant(input logic [3:0] mask, input int ptr);
    int best;
    best = -1;
    for (int i = NREQ - 1; i >= 0; i--) if (mask[i] && i >= ptr) best = i;
    if (best < 0) for (int i = NREQ - 1; i >= 0; i--) if (mask[i]) best = i;
    return best;
  endfunction

  task automatic pack_slices();
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*32 +: 32]  = a_addr[k];
      req_wdata[k*32 +: 32] = a_data[k];
    end
  endtask

  task automatic garble_slices();
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*32 +: 32]  = $urandom;
      req_wdata[k*32 +: 32] = $urandom;
    end
  endtask

  task automatic txn(input logic [3:0] mask, input logic [3:0] we_v, input int exp_g,
                     input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                     input int exp_lat, input string tag);
    int t0, n, aw0, w0, b0, ar0, r0;
    logic is_we;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    is_we = we_v[exp_g];
    @(posedge aclk); #1;
    req_valid = mask; req_we = we_v; pack_slices();
    @(negedge aclk);
    check($sformatf("%s_req_ready", tag), req_ready, 4'b0001 << exp_g);
    t0 = cyc;
    @(posedge aclk); #1;
    req_valid = '0;
    garble_slices();
    n = 0;
    do begin @(negedge aclk); n++; end while (rsp_valid == '0 && n < 80);
    check($sformatf("%s_rsp_valid", tag), rsp_valid, 4'b0001 << exp_g);
    check($sformatf("%s_rsp_resp", tag), rsp_resp, exp_resp);
    check($sformatf("%s_rsp_rdata", tag), rsp_rdata, exp_rdata);
    check($sformatf("%s_latency", tag), cyc - t0, exp_lat);
    if (is_we) begin
      check($sformatf("%s_awaddr", tag), cap_awaddr, a_addr[exp_g]);
      check($sformatf("%s_wdata", tag), cap_wdata, a_data[exp_g]);
    end else begin
      check($sformatf("%s_araddr", tag), cap_araddr, a_addr[exp_g]);
    end
    check($sformatf("%s_aw_hs", tag), aw_hs - aw0, is_we ? 1 : 0);
    check($sformatf("%s_w_hs", tag), w_hs - w0, is_we ? 1 : 0);
    check($sformatf("%s_b_hs", tag), b_hs - b0, is_we ? 1 : 0);
    check($sformatf("%s_ar_hs", tag), ar_hs - ar0, is_we ? 0 : 1);
    check($sformatf("%s_r_hs", tag), r_hs - r0, is_we ? 0 : 1);
    model_ptr = (exp_g + 1) % NREQ;
    if (!is_we) last_rd = cfg_rdata;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1 reset = 1;
    repeat (2) @(posedge aclk);
    #1 reset = 0;
    model_ptr = 0;
    last_rd   = '0;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  we_v;
    logic [31:0] addr;
    logic [31:0] data;
    int          da, dw, db, dar, dr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_g;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] mask, wev;
    int g, lat, n, g0, rc;

    reset = 1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    da = 0; dw = 0; db = 0; dar = 0; dr = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;

    //          mask     we       addr   data          da dw db dar dr resp   rdata         g  resp   rdata         lat
    vecs[0] = '{4'b0100, 4'b0100, 32'h10, 32'hDEADBEEF, 1, 1, 0, 0, 0, 2'b00, 32'h0,        2, 2'b00, 32'h0,        4};
    vecs[1] = '{4'b0001, 4'b0000, 32'h20, 32'h0,        0, 0, 0, 2, 5, 2'b10, 32'h12345678, 0, 2'b10, 32'h12345678, 10};
    vecs[2] = '{4'b0010, 4'b0010, 32'h30, 32'hCAFEF00D, 0, 3, 0, 0, 0, 2'b11, 32'h0,        1, 2'b11, 32'h12345678, 6};
    vecs[3] = '{4'b1000, 4'b0000, 32'h40, 32'h0,        0, 0, 0, 0, 0, 2'b01, 32'hA5A55A5A, 3, 2'b01, 32'hA5A55A5A, 3};
    vecs[4] = '{4'b0001, 4'b0001, 32'h50, 32'h0BADF00D, 2, 0, 2, 0, 0, 2'b10, 32'h0,        0, 2'b10, 32'hA5A55A5A, 7};

    repeat (2) @(negedge aclk);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_resp", rsp_resp, 0);
    @(posedge aclk); #1 reset = 0;
    model_ptr = 0;
    last_rd   = '0;

    foreach (vecs[i]) begin
      for (int k = 0; k < NREQ; k++) begin a_addr[k] = vecs[i].addr; a_data[k] = vecs[i].data; end
      da = vecs[i].da; dw = vecs[i].dw; db = vecs[i].db; dar = vecs[i].dar; dr = vecs[i].dr;
      cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp; cfg_rdata = vecs[i].rdata;
      txn(vecs[i].mask, vecs[i].we_v, vecs[i].exp_g, vecs[i].exp_resp, vecs[i].exp_rdata,
          vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 24; r++) begin
      mask = 4'($urandom_range(1, 15));
      wev  = 4'($urandom);
      for (int k = 0; k < NREQ; k++) begin a_addr[k] = $urandom; a_data[k] = $urandom; end
      da = $urandom_range(0, 3); dw = $urandom_range(0, 3); db = $urandom_range(0, 3);
      dar = $urandom_range(0, 3); dr = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom); cfg_rresp = 2'($urandom); cfg_rdata = $urandom;
      g   = model_grant(mask, model_ptr);
      lat = wev[g] ? 3 + ((da > dw) ? da : dw) + db : 3 + dar + dr;
      txn(mask, wev, g, wev[g] ? cfg_bresp : cfg_rresp, wev[g] ? last_rd : cfg_rdata,
          lat, $sformatf("rnd%0d", r));
    end

    // Reset while waiting for read data: transaction is dropped without a completion pulse.
    dar = 0; dr = 20; cfg_rdata = 32'h55AA55AA;
    @(posedge aclk); #1;
    req_valid = 4'b0100; req_we = '0;
    @(posedge aclk); #1;
    req_valid = '0;
    n = 0;
    while (!rready && n < 20) begin @(negedge aclk); n++; end
    check("rstseq_in_rd_data", rready, 1);
    rc = rsp_count;
    @(posedge aclk); #1 reset = 1;
    @(posedge aclk); #1 reset = 0;
    @(negedge aclk);
    check("rstseq_arvalid", arvalid, 0);
    check("rstseq_rready", rready, 0);
    check("rstseq_rsp_valid", rsp_valid, 0);
    repeat (25) @(negedge aclk);
    check("rstseq_no_pulse", rsp_count - rc, 0);
    check("rstseq_rsp_rdata", rsp_rdata, 0);
    model_ptr = 0;

    // All four requesters held: strict rotation from index 0 after reset.
    da = 0; dw = 0; db = 0; cfg_bresp = 2'b00;
    g0 = grant_log.size();
    @(posedge aclk); #1;
    req_we = '1; req_valid = '1; pack_slices();
    n = 0;
    while (grant_log.size() < g0 + 5 && n < 200) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 req_valid = '0;
    check("rr4_grant_count", grant_log.size() >= g0 + 5, 1);
    for (int i = 0; i < 5; i++)
      if (grant_log.size() > g0 + i) check($sformatf("rr4_grant%0d", i), grant_log[g0 + i], i % NREQ);
    repeat (10) @(negedge aclk);

    // Only requesters 1 and 3: after a grant to 1 the pointer is 2, so 3 wins, then 1 again.
    do_reset();
    g0 = grant_log.size();
    @(posedge aclk); #1;
    req_we = '1; req_valid = 4'b1010;
    n = 0;
    while (grant_log.size() < g0 + 3 && n < 200) begin @(negedge aclk); n++; end
    @(posedge aclk); #1 req_valid = '0;
    check("rr13_grant_count", grant_log.size() >= g0 + 3, 1);
    if (grant_log.size() >= g0 + 3) begin
      check("rr13_grant0", grant_log[g0], 1);
      check("rr13_grant1", grant_log[g0 + 1], 3);
      check("rr13_grant2", grant_log[g0 + 2], 1);
    end
    repeat (10) @(negedge aclk);

    check("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
